// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared definitions for the multiplexed 7-segment scanner:
//                blank pattern, scanner state encoding, decimal segment
//                patterns (active-high, {a,b,c,d,e,f,g}) and a BCD helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scanner state encoding
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t SCAN = 1'b1;

    // Decimal digit patterns, seg[6] = a ... seg[0] = g
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    function automatic logic is_bcd(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational BCD to 7-segment decoder (active-high).
//                Codes above 9 produce the blank pattern.
//  Ports       : i_code - 4-bit BCD code
//                o_seg  - segments {a,b,c,d,e,f,g}
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scanner for NUM_DIGITS common-anode digits
//                sharing one decoder. Double-buffers the BCD value so frames
//                never tear, inserts anode dead-time at the start of each
//                slot, optionally suppresses leading zeros, blanks non-BCD.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                enable        - 1 = scan, 0 = display dark
//                load, value   - capture packed BCD value (digit 0 = LSN)
//                lz_blank      - suppress leading zeros
//                seg           - segments {a..g}, active-high
//                an            - anodes, active-low, an[k] = digit k
//                frame_done    - pulse when the last digit slot ends
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_PRE_W = $clog2(REFRESH_DIV);

    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_PRE_W-1:0]    c_PRE_LAST = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_PRE_W-1:0]    c_DEAD     = c_PRE_W'(DEAD_CYC);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF   = '1;
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE   = NUM_DIGITS'(1);

    state_t                  r_state;
    logic [c_PRE_W-1:0]      r_presc;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_flag;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_scan;
    logic                    w_slot_end;
    logic                    w_boundary;
    logic [3:0]              w_digit;
    logic [6:0]              w_dec_seg;
    logic [NUM_DIGITS-1:0]   w_lead_zero;
    logic                    w_run;
    logic                    w_blank;

    // Scanning only while enable is held; dropping enable darkens the
    // outputs on the very next edge.
    assign w_scan     = (r_state == SCAN) && enable;
    assign w_slot_end = w_scan && (r_presc == c_PRE_LAST);
    assign w_boundary = w_slot_end && (r_idx == c_IDX_LAST);
    assign w_digit    = r_active[{r_idx, 2'b00} +: 4];

    // w_lead_zero[k] = digit k and every more-significant digit are zero
    always_comb begin
        w_run       = 1'b1;
        w_lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run          = w_run & (r_active[4*k +: 4] == 4'd0);
            w_lead_zero[k] = w_run;
        end
    end

    // Digit 0 always shows, so an all-zero value still displays "0"
    assign w_blank = !is_bcd(w_digit) ||
                     (lz_blank && (r_idx != '0) && w_lead_zero[r_idx]);

    seg7_decoder u_decoder (
        .i_code (w_digit),
        .o_seg  (w_dec_seg)
    );

    // State, prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_presc <= '0;
                    r_idx   <= '0;
                    if (enable) begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_presc <= '0;
                        r_idx   <= '0;
                    end else if (w_slot_end) begin
                        r_presc <= '0;
                        r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Double buffer: the active value only changes on a frame boundary.
    // A load coinciding with the boundary bypasses the pending buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_flag <= 1'b0;
        end else if (w_boundary && load) begin
            r_active    <= value;
            r_pend_flag <= 1'b0;
        end else begin
            if (w_boundary && r_pend_flag) begin
                r_active    <= r_pending;
                r_pend_flag <= 1'b0;
            end
            if (load) begin
                r_pending   <= value;
                r_pend_flag <= 1'b1;
            end
        end
    end

    // Registered outputs, one cycle behind prescaler/index/active buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= SEG_BLANK;
            r_an         <= c_AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_scan) begin
                r_an  <= (r_presc < c_DEAD) ? c_AN_OFF : ~(c_AN_ONE << r_idx);
                r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
            end else begin
                r_an  <= c_AN_OFF;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Scoreboard bench for seg7_scan_ctrl (4 digits, 4-cycle
//                slots, 1 dead cycle). Stimulus pushes the hand-derived lit
//                cycles of each frame; a monitor pops one entry for every
//                cycle in which an anode is driven.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

    localparam int c_ND = 4;
    localparam int c_RD = 4;
    localparam int c_DC = 1;

    // Hand-written segment patterns {a,b,c,d,e,f,g}
    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] BL = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] value = 16'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (c_ND),
        .REFRESH_DIV (c_RD),
        .DEAD_CYC    (c_DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    // ---------------- expectation builders ----------------
    task automatic push_slot(input int d, input logic [6:0] s, input int n, input logic last_fd);
        exp_t e;
        for (int l = 0; l < n; l++) begin
            e.an  = ~(4'b0001 << d);
            e.seg = s;
            e.fd  = last_fd && (l == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // one full frame, digits given most-significant first
    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        push_slot(0, s0, 3, 1'b0);
        push_slot(1, s1, 3, 1'b0);
        push_slot(2, s2, 3, 1'b0);
        push_slot(3, s3, 3, 1'b1);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (an != 4'hF) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_lit: got an=%b seg=%b fd=%b, required no lit digit",
                             an, seg, frame_done);
                end else begin
                    e = exp_q.pop_front();
                    if ({an, seg, frame_done} !== e) begin
                        n_fail++;
                        $display("FAIL scan_out @%0t: got an=%b seg=%b fd=%b, required an=%b seg=%b fd=%b",
                                 $time, an, seg, frame_done, e.an, e.seg, e.fd);
                    end
                end
            end else if (frame_done) begin
                n_tests++;
                n_fail++;
                $display("FAIL fd_in_dark @%0t: got fd=1 with an=1111, required fd=0", $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_dark(input string name);
        check_val({name, "_an"},  {12'h0, an},         16'h000F);
        check_val({name, "_seg"}, {9'h0, seg},         16'h0000);
        check_val({name, "_fd"},  {15'h0, frame_done}, 16'h0000);
    endtask

    task automatic check_drain(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending lit cycles, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // returns at the negedge on which frame_done is high
    task automatic wait_fd(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no frame_done in 40 cycles, required a pulse", name);
        end
    endtask

    task automatic end_phase(input string name);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_dark(name);
        check_drain(name);
    endtask

    task automatic idle_load(input logic [15:0] v);
        @(negedge clk);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset held with enable and load active: nothing must leak through
        rst    = 1'b1;
        enable = 1'b1;
        load   = 1'b1;
        value  = 16'h9876;
        repeat (3) begin
            @(negedge clk);
            check_dark("reset");
        end
        rst    = 1'b0;
        enable = 1'b0;
        load   = 1'b0;

        // A: 1234, first frame still shows the reset active buffer (0000)
        lz_blank = 1'b0;
        idle_load(16'h1234);
        push_frame(P0, P0, P0, P0);
        push_frame(P1, P2, P3, P4);
        enable = 1'b1;
        wait_fd("a1");
        wait_fd("a2");
        end_phase("a");

        // B: leading-zero suppression on 0070
        lz_blank = 1'b1;
        idle_load(16'h0070);
        push_frame(P1, P2, P3, P4);
        push_frame(BL, BL, P7, P0);
        enable = 1'b1;
        wait_fd("b1");
        wait_fd("b2");
        end_phase("b");

        // C: all zeros with suppression, only digit 0 lit
        idle_load(16'h0000);
        push_frame(BL, BL, P7, P0);
        push_frame(BL, BL, BL, P0);
        enable = 1'b1;
        wait_fd("c1");
        wait_fd("c2");
        end_phase("c");

        // D: non-BCD code blanks its digit
        lz_blank = 1'b0;
        idle_load(16'h00A5);
        push_frame(P0, P0, P0, P0);
        push_frame(P0, P0, BL, P5);
        enable = 1'b1;
        wait_fd("d1");
        wait_fd("d2");
        end_phase("d");

        // E: tear-free updates, mid-frame loads and a boundary-cycle load
        idle_load(16'h1111);
        push_frame(P0, P0, BL, P5);
        push_frame(P1, P1, P1, P1);
        push_frame(P2, P2, P2, P2);
        push_frame(P1, P1, P1, P1);
        push_frame(P2, P2, P2, P2);
        push_frame(P2, P2, P2, P2);
        enable = 1'b1;
        wait_fd("e1");
        repeat (5) @(posedge clk);
        #1 load = 1'b1; value = 16'h2222;
        @(posedge clk);
        #1 load = 1'b0;
        wait_fd("e2");
        repeat (5) @(posedge clk);
        #1 load = 1'b1; value = 16'h1111;
        @(posedge clk);
        #1 load = 1'b0;
        wait_fd("e3");
        repeat (15) @(posedge clk);
        #1 load = 1'b1; value = 16'h2222;
        @(posedge clk);
        #1 load = 1'b0;
        wait_fd("e4");
        wait_fd("e5");
        wait_fd("e6");
        end_phase("e");

        // F1: enable drops mid-slot (during digit 1 slot of second frame)
        push_frame(P2, P2, P2, P2);
        push_slot(0, P2, 3, 1'b0);
        push_slot(1, P2, 1, 1'b0);
        @(negedge clk);
        enable = 1'b1;
        wait_fd("f1");
        repeat (6) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_dark("drop");
        check_drain("drop");

        // F2: re-enable restarts at digit 0 with a full dead cycle
        push_frame(P2, P2, P2, P2);
        push_slot(0, P2, 3, 1'b0);
        push_slot(1, P2, 1, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        check_val("reen_idle_an", {12'h0, an}, 16'h000F);
        @(negedge clk);
        check_val("reen_dead_an", {12'h0, an}, 16'h000F);
        wait_fd("f2");

        // F3: reset together with load mid-slot
        repeat (6) @(posedge clk);
        #1 rst = 1'b1; load = 1'b1; value = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        check_dark("rst_load");
        rst  = 1'b0;
        load = 1'b0;
        check_drain("rst_load");
        // active cleared to 0 and no pending transfer at the next boundary
        push_frame(P0, P0, P0, P0);
        push_frame(P0, P0, P0, P0);
        wait_fd("f3a");
        wait_fd("f3b");
        end_phase("f3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
